// File: rtl/alu1bit_pkg.sv
// Shared definitions for the 1-bit ALU stimulus/response pair: opcodes, checker
// FSM encoding and the captured-vector layout.
package alu1bit_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2
    } state_t;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] op;
    } vec_t;

    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu1bit_ref_model.sv
// Combinational golden model of the 1-bit ALU: expected carry/result and
// whether the carry is meaningful for the opcode.
module alu1bit_ref_model
    import alu1bit_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       ec,
    output logic       er,
    output logic       chk_cout
);

    logic [1:0] sum;

    always_comb begin
        // NOTE: every output gets a default before the case so no path holds an old value (no latch).
        sum      = 2'b00;
        chk_cout = is_arith(op);
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b} + {1'b0, cin};
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {1'b0, cin};
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            default: sum = 2'b00;
        endcase
        ec = sum[1];
        er = sum[0];
    end

endmodule

// File: rtl/alu1bit_checker.sv
// Response checker for the 1-bit ALU: captures each applied vector, waits a settle
// window, compares DUT outputs against the golden model and keeps run statistics.
module alu1bit_checker
    import alu1bit_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             f1,
    input  logic             f0,
    input  logic             cout,
    input  logic             res,
    input  logic             clr,
    output logic             busy,
    output logic             chk_done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             ovr,
    output logic [6:0]       first_fail
);

    localparam int              SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t        state;
    vec_t          vec_q;
    logic [SW-1:0] settle_cnt;
    logic          ec;
    logic          er;
    logic          chk_cout;
    logic          ok;

    alu1bit_ref_model u_ref (
        .a        (vec_q.a),
        .b        (vec_q.b),
        .cin      (vec_q.cin),
        .op       (vec_q.op),
        .ec       (ec),
        .er       (er),
        .chk_cout (chk_cout)
    );

    // An unknown on cout/res makes ok non-true, which falls into the failing branch.
    assign ok = (res == er) && (!chk_cout || (cout == ec));

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec_q      <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            chk_done   <= 1'b0;
            mismatch   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err        <= 1'b0;
            ovr        <= 1'b0;
            first_fail <= '0;
        end else begin
            chk_done <= 1'b0;
            mismatch <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (vec_valid) begin
                        vec_q      <= {a, b, cin, f1, f0};
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_COMPARE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    chk_done <= 1'b1;
                    if (ok) begin
                        mismatch <= 1'b0;
                        if (!clr && pass_cnt != CNT_MAX) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end else begin
                        mismatch <= 1'b1;
                        if (!clr) begin
                            if (fail_cnt != CNT_MAX) begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                            if (!err) begin
                                first_fail <= {vec_q, cout, res};
                            end
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (vec_valid && state != ST_IDLE) begin
                ovr <= 1'b1;
            end

            // Clear overrides any statistic update made by a coincident compare.
            if (clr) begin
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                err        <= 1'b0;
                ovr        <= 1'b0;
                first_fail <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu1bit_checker.sv
// Scoreboard bench for alu1bit_checker: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; expected compare outcomes are queued at drive time and retired on chk_done.
module tb_alu1bit_checker;

    localparam int SETTLE = 4;
    localparam int LAT    = SETTLE + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vec_valid = 1'b0;
    logic       a = 1'b0, b = 1'b0, cin = 1'b0, f1 = 1'b0, f0 = 1'b0;
    logic       cout = 1'b0, res = 1'b0, clr = 1'b0;

    logic       busy, chk_done, mismatch, err, ovr;
    logic [7:0] pass_cnt, fail_cnt;
    logic [6:0] first_fail;
    logic       busy2, chk_done2, mismatch2, err2, ovr2;
    logic [1:0] pass_cnt2, fail_cnt2;
    logic [6:0] first_fail2;

    alu1bit_checker #(.SETTLE_CYC(SETTLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .a(a), .b(b), .cin(cin),
        .f1(f1), .f0(f0), .cout(cout), .res(res), .clr(clr), .busy(busy),
        .chk_done(chk_done), .mismatch(mismatch), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .err(err), .ovr(ovr), .first_fail(first_fail)
    );

    alu1bit_checker #(.SETTLE_CYC(SETTLE), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .a(a), .b(b), .cin(cin),
        .f1(f1), .f0(f0), .cout(cout), .res(res), .clr(clr), .busy(busy2),
        .chk_done(chk_done2), .mismatch(mismatch2), .pass_cnt(pass_cnt2),
        .fail_cnt(fail_cnt2), .err(err2), .ovr(ovr2), .first_fail(first_fail2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] vec;
        logic       cout;
        logic       res;
        logic       fail;
        int         cyc;
    } sb_t;

    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_pass8 = 0, m_fail8 = 0, m_pass2 = 0, m_fail2 = 0;
    logic m_err = 1'b0;
    logic m_ovr = 1'b0;
    logic [6:0] m_first = '0;
    logic discard_next = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {expected carry, expected result}.
    function automatic logic [1:0] golden(input logic a_i, input logic b_i, input logic cin_i,
                                          input logic [1:0] op);
        int s;
        case (op)
            2'b00:   s = int'(a_i) + int'(b_i) + int'(cin_i);
            2'b01:   s = int'(a_i) + (b_i ? 0 : 1) + int'(cin_i);
            2'b10:   s = (a_i & b_i) ? 1 : 0;
            default: s = (a_i | b_i) ? 1 : 0;
        endcase
        return {s >= 2, (s % 2) == 1};
    endfunction

    function automatic logic exp_fail(input logic a_i, input logic b_i, input logic cin_i,
                                      input logic [1:0] op, input logic co, input logic r);
        logic [1:0] g;
        g = golden(a_i, b_i, cin_i, op);
        if (op[1]) return r !== g[0];
        return (co !== g[1]) || (r !== g[0]);
    endfunction

    // Called at a falling edge; drives a one-cycle strobe and queues the expected outcome.
    task automatic send(input logic a_i, input logic b_i, input logic cin_i, input logic [1:0] op,
                        input logic co, input logic r);
        sb_t e;
        a = a_i; b = b_i; cin = cin_i; {f1, f0} = op; cout = co; res = r;
        vec_valid = 1'b1;
        e.vec  = {a_i, b_i, cin_i, op};
        e.cout = co;
        e.res  = r;
        e.fail = exp_fail(a_i, b_i, cin_i, op, co, r);
        e.cyc  = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        vec_valid = 1'b0;
        check("busy_after_capture", busy, 1);
    endtask

    // Returns at the falling edge where chk_done is high, so a following send is back-to-back.
    task automatic wait_done;
        int n = 0;
        while (!chk_done && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (!chk_done) begin
            check("chk_done_timeout", 0, 1);
            sb_q.delete();
        end
    endtask

    task automatic model_clear;
        m_pass8 = 0; m_fail8 = 0; m_pass2 = 0; m_fail2 = 0;
        m_err = 1'b0; m_ovr = 1'b0; m_first = '0;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check("clr_pass_cnt", pass_cnt, 0);
        check("clr_fail_cnt", fail_cnt, 0);
        check("clr_err", err, 0);
        check("clr_ovr", ovr, 0);
        check("clr_first_fail", first_fail, 0);
        check("clr_pass_cnt2", pass_cnt2, 0);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && !chk_done && mismatch) check("mismatch_without_done", mismatch, 0);
        if (rst_n && chk_done) begin
            if (sb_q.size() == 0) begin
                check("spurious_chk_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("latency", cyc - e.cyc, LAT);
                check("mismatch", mismatch, e.fail);
                check("chk_done_u2", chk_done2, 1);
                check("mismatch_u2", mismatch2, e.fail);
                if (discard_next) begin
                    discard_next = 1'b0;
                end else if (!e.fail) begin
                    if (m_pass8 < 255) m_pass8++;
                    if (m_pass2 < 3) m_pass2++;
                end else begin
                    if (m_fail8 < 255) m_fail8++;
                    if (m_fail2 < 3) m_fail2++;
                    if (!m_err) m_first = {e.vec, e.cout, e.res};
                    m_err = 1'b1;
                end
                check("pass_cnt", pass_cnt, m_pass8);
                check("fail_cnt", fail_cnt, m_fail8);
                check("pass_cnt2", pass_cnt2, m_pass2);
                check("fail_cnt2", fail_cnt2, m_fail2);
                check("err", err, m_err);
                check("first_fail", first_fail, m_first);
                check("first_fail2", first_fail2, m_first);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] v;
        logic [1:0] op;
        logic [1:0] g;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_chk_done", chk_done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_err", err, 0);
        check("rst_ovr", ovr, 0);
        check("rst_first_fail", first_fail, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Add and subtract, then a forced wrong result.
        send(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0); wait_done();
        send(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1); wait_done();
        send(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0); wait_done();
        check("first_fail_value", first_fail, 7'b0110100);

        // Logic ops ignore cout.
        send(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0); wait_done();
        send(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1); wait_done();

        // A second failure leaves first_fail unchanged.
        send(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0); wait_done();

        // Overrun: strobe again while the first vector is settling.
        send(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        a = 1'b0;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        m_ovr = 1'b1;
        wait_done();
        repeat (2 * LAT) @(negedge clk);
        check("ovr", ovr, m_ovr);
        check("ovr2", ovr2, m_ovr);

        do_clr();

        // Five passing vectors back-to-back; the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            v  = 3'(i + 3);
            op = 2'(i);
            g  = golden(v[0], v[1], v[2], op);
            if (i != 0) wait_done();
            send(v[0], v[1], v[2], op, g[1], g[0]);
        end
        wait_done();
        check("sat_pass_cnt", pass_cnt, 5);
        check("sat_pass_cnt2", pass_cnt2, 3);
        @(negedge clk);
        do_clr();

        // Clear landing on the compare cycle of a failing vector.
        send(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("pre_clr_chk_done", chk_done, 0);
        clr = 1'b1;
        discard_next = 1'b1;
        model_clear();
        @(negedge clk);
        clr = 1'b0;
        check("clr_cmp_chk_done", chk_done, 1);
        check("clr_cmp_mismatch", mismatch, 1);
        check("clr_cmp_err", err, 0);
        check("clr_cmp_fail_cnt", fail_cnt, 0);
        @(negedge clk);

        // Asynchronous reset during SETTLE aborts the check.
        send(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_busy2", busy2, 0);
        sb_q.delete();
        model_clear();
        @(negedge clk);
        check("rst_mid_pass_cnt", pass_cnt, 0);
        check("rst_mid_chk_done", chk_done, 0);
        rst_n = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        send(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1); wait_done();
        check("post_rst_pass_cnt", pass_cnt, 1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
